// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - M-stage data memory to request/ack bus bridge (IDLE/ADDR/DATA/DONE).
// Optional bus wait timeout enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_en,
   input  logic [3:0]  mem_wen,
   input  logic [1:0]  load_size,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic        except_flush,
   output logic [31:0] mem_rdata,
   output logic        mem_stall,
   output logic        bus_err,
   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t      state;
   state_t      next_state;
   logic        flush_pend;
   logic        timed_out;
   logic        tmo_fire;
   logic        load_done;
   logic        discard;
   logic [1:0]  store_size;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("dmem_bridge: TIMEOUT must fit the 8-bit wait counter");
   end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
   logic [7:0] wait_cnt;

   assign timed_out = ((state == ADDR) || (state == DATA)) && (wait_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= 8'd0;
      end else if (next_state != state) begin
         wait_cnt <= 8'd0;
      end else if ((state == ADDR) || (state == DATA)) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_err <= 1'b0;
      end else begin
         bus_err <= tmo_fire;
      end
   end
`else
   assign timed_out = 1'b0;
   assign bus_err   = 1'b0;
`endif

   // Flush that arrives once the bus has accepted the address cannot cancel it.
   assign discard = flush_pend | except_flush;

   always_comb begin
      next_state = state;
      tmo_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_en && !except_flush) begin
               next_state = ADDR;
            end
         end
         ADDR: begin
            if (addr_ok && data_ok) begin
               next_state = except_flush ? IDLE : DONE;
            end else if (addr_ok) begin
               next_state = DATA;
            end else if (except_flush) begin
               next_state = IDLE;
            end else if (timed_out) begin
               next_state = DONE;
               tmo_fire   = 1'b1;
            end
         end
         DATA: begin
            if (data_ok) begin
               next_state = discard ? IDLE : DONE;
            end else if (timed_out) begin
               next_state = DONE;
               tmo_fire   = 1'b1;
            end
         end
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      mem_stall = 1'b0;
      case (state)
         IDLE:    mem_stall = mem_en & ~except_flush;
         ADDR:    mem_stall = mem_en & ~(except_flush & ~addr_ok);
         DATA:    mem_stall = mem_en | flush_pend;
         default: mem_stall = 1'b0;
      endcase
   end

   always_comb begin
      store_size = 2'd2;
      case (mem_wen)
         4'b1111:                            store_size = 2'd2;
         4'b0011, 4'b1100:                   store_size = 2'd1;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: store_size = 2'd0;
         default:                            store_size = 2'd2;
      endcase
   end

   assign load_done = !wr && !discard &&
                      (((state == ADDR) && addr_ok && data_ok) || ((state == DATA) && data_ok));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_pend <= 1'b0;
      end else if (next_state == DATA) begin
         flush_pend <= flush_pend | except_flush;
      end else begin
         flush_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req       <= 1'b0;
         wr        <= 1'b0;
         size      <= 2'd0;
         addr      <= 32'd0;
         wdata     <= 32'd0;
         mem_rdata <= 32'd0;
      end else begin
         req <= (next_state == ADDR);
         if ((state == IDLE) && (next_state == ADDR)) begin
            addr  <= mem_addr;
            wdata <= mem_wdata;
            wr    <= (mem_wen != 4'd0);
            size  <= (mem_wen != 4'd0) ? store_size : load_size;
         end
         if (load_done) begin
            mem_rdata <= rdata;
         end else if (tmo_fire) begin
            mem_rdata <= 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge.
// Timeout scenario runs only when DMEM_BRIDGE_TIMEOUT_EN is defined.
module tb_dmem_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [1:0]  load_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        except_flush;
   logic [31:0] mem_rdata;
   logic        mem_stall;
   logic        bus_err;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   int checks   = 0;
   int failures = 0;
   int stall_cycles;

   dmem_bridge #(.TIMEOUT(255)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_en       (mem_en),
      .mem_wen      (mem_wen),
      .load_size    (load_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .except_flush (except_flush),
      .mem_rdata    (mem_rdata),
      .mem_stall    (mem_stall),
      .bus_err      (bus_err),
      .req          (req),
      .wr           (wr),
      .size         (size),
      .addr         (addr),
      .wdata        (wdata),
      .addr_ok      (addr_ok),
      .data_ok      (data_ok),
      .rdata        (rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; mem_en = 1'b0; mem_wen = 4'd0; load_size = 2'd0;
      mem_addr = 32'd0; mem_wdata = 32'd0; except_flush = 1'b0;
      addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;

      // reset state
      tick(); tick(); smp();
      check("rst_req", {31'd0, req}, 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
      check("rst_addr", addr, 32'd0);
      check("rst_bus_err", {31'd0, bus_err}, 32'd0);
      tick(); rst = 1'b0;

      // load word, single-cycle bus response
      tick(); mem_en = 1'b1; mem_wen = 4'd0; load_size = 2'd2; mem_addr = 32'h10;
      smp();
      check("lw_idle_stall", {31'd0, mem_stall}, 32'd1);
      check("lw_idle_req", {31'd0, req}, 32'd0);
      tick(); addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hDEADBEEF;
      smp();
      check("lw_req", {31'd0, req}, 32'd1);
      check("lw_size", {30'd0, size}, 32'd2);
      check("lw_wr", {31'd0, wr}, 32'd0);
      check("lw_addr", addr, 32'h10);
      check("lw_addr_stall", {31'd0, mem_stall}, 32'd1);
      tick(); addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
      smp();
      check("lw_done_rdata", mem_rdata, 32'hDEADBEEF);
      check("lw_done_stall", {31'd0, mem_stall}, 32'd0);
      check("lw_done_req", {31'd0, req}, 32'd0);

      // store half, back-to-back after DONE; addr_ok in 3rd ADDR cycle, data_ok 2 later
      tick(); mem_wen = 4'b1100; mem_wdata = 32'hABCD0000; mem_addr = 32'h24;
      stall_cycles = 0;
      for (int k = 0; k < 8; k++) begin
         addr_ok = (k == 3);
         data_ok = (k == 5);
         if (k == 6) mem_en = 1'b0;
         smp();
         if (mem_stall) stall_cycles++;
         if (k >= 1 && k <= 3) begin
            check("sh_req", {31'd0, req}, 32'd1);
            check("sh_wr", {31'd0, wr}, 32'd1);
            check("sh_size", {30'd0, size}, 32'd1);
            check("sh_addr", addr, 32'h24);
            check("sh_wdata", wdata, 32'hABCD0000);
         end
         tick();
      end
      addr_ok = 1'b0; data_ok = 1'b0;
      check("sh_stall_cycles", stall_cycles, 32'd6);
      check("sh_rdata_kept", mem_rdata, 32'hDEADBEEF);

      // flush while waiting for addr_ok
      mem_en = 1'b1; mem_wen = 4'd0; load_size = 2'd0; mem_addr = 32'h30;
      smp();
      check("fa_idle_stall", {31'd0, mem_stall}, 32'd1);
      tick(); except_flush = 1'b1;
      smp();
      check("fa_req", {31'd0, req}, 32'd1);
      check("fa_stall_drop", {31'd0, mem_stall}, 32'd0);
      tick(); except_flush = 1'b0; mem_en = 1'b0;
      smp();
      check("fa_req_drop", {31'd0, req}, 32'd0);
      check("fa_rdata_kept", mem_rdata, 32'hDEADBEEF);

      // new load after the dropped one, then flush once in DATA
      tick(); mem_en = 1'b1; mem_wen = 4'd0; load_size = 2'd2; mem_addr = 32'h40;
      smp();
      check("fd_idle_stall", {31'd0, mem_stall}, 32'd1);
      tick(); addr_ok = 1'b1;
      smp();
      check("fd_req", {31'd0, req}, 32'd1);
      check("fd_addr", addr, 32'h40);
      tick(); addr_ok = 1'b0; except_flush = 1'b1;
      smp();
      check("fd_stall_flush", {31'd0, mem_stall}, 32'd1);
      check("fd_req_low", {31'd0, req}, 32'd0);
      tick(); except_flush = 1'b0;
      smp();
      check("fd_stall_wait", {31'd0, mem_stall}, 32'd1);
      tick(); data_ok = 1'b1; rdata = 32'h12345678;
      smp();
      check("fd_stall_dataok", {31'd0, mem_stall}, 32'd1);
      tick(); data_ok = 1'b0; rdata = 32'd0; load_size = 2'd1; mem_addr = 32'h50;
      smp();
      check("fd_idle_not_done", {31'd0, mem_stall}, 32'd1);
      check("fd_rdata_kept", mem_rdata, 32'hDEADBEEF);
      check("fd_req_low2", {31'd0, req}, 32'd0);

      // reset in DATA, then a stray data_ok
      tick(); addr_ok = 1'b1;
      smp();
      check("rd_req", {31'd0, req}, 32'd1);
      check("rd_size", {30'd0, size}, 32'd1);
      check("rd_addr", addr, 32'h50);
      tick(); addr_ok = 1'b0;
      smp();
      check("rd_data_stall", {31'd0, mem_stall}, 32'd1);
      #1 rst = 1'b1; mem_en = 1'b0;
      #1;
      check("rd_async_req", {31'd0, req}, 32'd0);
      check("rd_async_addr", addr, 32'd0);
      check("rd_async_size", {30'd0, size}, 32'd0);
      check("rd_async_rdata", mem_rdata, 32'd0);
      tick(); rst = 1'b0; data_ok = 1'b1; rdata = 32'hCAFEF00D;
      smp();
      tick(); data_ok = 1'b0; rdata = 32'd0;
      smp();
      check("rd_late_rdata", mem_rdata, 32'd0);
      check("rd_late_req", {31'd0, req}, 32'd0);
      check("rd_late_stall", {31'd0, mem_stall}, 32'd0);
      check("rd_late_wr", {31'd0, wr}, 32'd0);
      check("rd_late_wdata", wdata, 32'd0);

      // byte store proves the bridge restarted from IDLE
      tick(); mem_en = 1'b1; mem_wen = 4'b0010; mem_wdata = 32'h0000AA00; mem_addr = 32'h61;
      tick(); addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h55555555;
      smp();
      check("sb_req", {31'd0, req}, 32'd1);
      check("sb_wr", {31'd0, wr}, 32'd1);
      check("sb_size", {30'd0, size}, 32'd0);
      check("sb_wdata", wdata, 32'h0000AA00);
      check("sb_addr", addr, 32'h61);
      tick(); addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
      smp();
      check("sb_done_stall", {31'd0, mem_stall}, 32'd0);
      check("sb_rdata_kept", mem_rdata, 32'd0);
      tick(); mem_en = 1'b0;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
      begin
         int req_cycles;
         int err_pulses;
         logic seen;
         tick(); mem_en = 1'b1; mem_wen = 4'd0; load_size = 2'd2; mem_addr = 32'h70;
         tick(); addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h11111111;
         tick(); addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
         smp();
         check("to_prime_rdata", mem_rdata, 32'h11111111);
         tick(); mem_addr = 32'h74;
         req_cycles = 0; err_pulses = 0; seen = 1'b0;
         for (int k = 0; k < 270; k++) begin
            smp();
            if (req) req_cycles++;
            if (bus_err) begin
               err_pulses++;
               seen = 1'b1;
               check("to_rdata_zero", mem_rdata, 32'd0);
               check("to_stall_drop", {31'd0, mem_stall}, 32'd0);
            end
            tick();
            if (seen) mem_en = 1'b0;
         end
         check("to_req_cycles", req_cycles, 32'd255);
         check("to_err_pulses", err_pulses, 32'd1);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 255, is the number of bus-wait cycles before a bus error (used only with DMEM_BRIDGE_TIMEOUT_EN).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_en  in  1  M-stage memory access valid (load or store).
REQ-005 mem_wen  in  4  byte write enables; nonzero means store, 0 means load.
REQ-006 load_size  in  2  load width: 0 = byte, 1 = half, 2 = word.
REQ-007 mem_addr  in  32  M-stage effective address.
REQ-008 mem_wdata  in  32  lane-aligned store data.
REQ-009 except_flush  in  1  M-stage exception flush.
REQ-010 mem_rdata  out  32  load data returned to the W-stage register.
REQ-011 mem_stall  out  1  stall request to the hazard unit.
REQ-012 bus_err  out  1  one-cycle pulse on a bus timeout.
REQ-013 req, wr  out  1 each  bus request and write qualifier.
REQ-014 size  out  2  bus transfer size.
REQ-015 addr, wdata  out  32 each  bus address and bus write data.
REQ-016 addr_ok, data_ok  in  1 each  bus address-accept and data-complete strobes.
REQ-017 rdata  in  32  bus read data, valid with data_ok.

Function
REQ-018 FSM states: IDLE, ADDR, DATA, DONE.
REQ-019 Transitions:
- IDLE goes to ADDR when mem_en=1 and except_flush=0.
- ADDR goes to DATA on addr_ok, or directly to DONE on addr_ok and data_ok in the same cycle.
- DATA goes to DONE on data_ok.
- DONE goes to IDLE unconditionally.
REQ-020 req=1 only in ADDR.
REQ-021 addr, wr, size and wdata are registered at IDLE->ADDR and held stable until addr_ok.
REQ-022 wr = (mem_wen != 0).
REQ-023 Store size from mem_wen:
- 1111 gives 2.
- 0011 or 1100 gives 1.
- A single bit set gives 0.
REQ-024 Load size = load_size.
REQ-025 mem_stall = mem_en & (state != DONE).
REQ-026 mem_stall is combinational, so a request in IDLE stalls in the same cycle.
REQ-027 rdata is captured into mem_rdata on the data_ok cycle of a load and held until the next load completes.
REQ-028 Stores leave mem_rdata unchanged.
REQ-029 Minimum access latency is 2 cycles (IDLE to ADDR, then addr_ok and data_ok together to DONE); mem_stall deasserts in DONE.
REQ-030 except_flush in IDLE or ADDR before addr_ok: the request is dropped, next state is IDLE, req drops next cycle, and mem_stall deasserts that cycle.
REQ-031 except_flush in DATA is latched; the transaction is not cancellable on the bus.
- mem_stall stays 1 until data_ok.
- The FSM then goes to IDLE, not DONE, and rdata is discarded.
REQ-032 Back-to-back accesses: a new mem_en seen in IDLE right after DONE starts a new access with no extra bubble.
REQ-033 addr_ok or data_ok outside ADDR/DATA is ignored.

Reset
REQ-034 rst forces state IDLE and clears the timeout counter.
REQ-035 rst clears every output register to 0: req, wr, size, addr, wdata, mem_rdata, bus_err.
REQ-036 rst asserted mid-transaction abandons the transaction; a late data_ok after reset is ignored.

Configuration
REQ-037 Macro DMEM_BRIDGE_TIMEOUT_EN, when defined, adds an 8-bit wait counter:
- The counter increments each cycle in ADDR or DATA and clears on every state change.
- When it reaches TIMEOUT, the FSM goes to DONE, mem_rdata is set to 0, and bus_err pulses for one cycle.
REQ-038 With DMEM_BRIDGE_TIMEOUT_EN undefined, there is no counter, the bridge waits indefinitely, and bus_err is tied to 0.

Verification
REQ-039 Load word: mem_en=1, mem_wen=0, load_size=2, addr 0x00000010.
- Required: req=1 with size=2, wr=0.
- Stimulus: addr_ok and data_ok next cycle with rdata 0xDEADBEEF.
- Required: mem_rdata=0xDEADBEEF and mem_stall=0 in DONE.
REQ-040 Store half: mem_wen=1100, wdata 0xABCD0000.
- Stimulus: addr_ok after 3 cycles, data_ok after 2 more.
- Required: wr=1, size=1, addr/wdata stable throughout, and mem_stall=1 for exactly 6 cycles.
REQ-041 Flush in ADDR: except_flush=1 before addr_ok.
- Required: req=0 next cycle, FSM in IDLE, mem_rdata unchanged.
REQ-042 Flush in DATA: except_flush=1 after addr_ok.
- Required: mem_stall held until data_ok (rdata 0x12345678), then IDLE with mem_rdata unchanged.
REQ-043 Reset mid-DATA, then a spurious data_ok.
- Required: all outputs 0 and FSM in IDLE.
REQ-044 With DMEM_BRIDGE_TIMEOUT_EN and TIMEOUT=255: req held with no addr_ok.
- Required: after 255 cycles bus_err pulses once, mem_rdata=0, mem_stall falls.
